// File: rtl/spi_slave_9952.sv
// spi_slave_9952: AD9952-style 3-wire SPI register responder with buffer/active register pairs
module spi_slave_9952 #(
  parameter int CS_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        n_cs,
  input  logic        sclk,
  input  logic        sdio_i,
  output logic        sdio_o,
  output logic        sdio_oe,
  input  logic        io_update,
  output logic [31:0] cfr1,
  output logic [23:0] cfr2,
  output logic [15:0] asf,
  output logic [7:0]  arr,
  output logic [31:0] ftw,
  output logic [15:0] pow,
  output logic        update_stb,
  output logic        wr_done,
  output logic [4:0]  wr_addr,
  output logic        bad_addr
);
  typedef enum logic [2:0] {IDLE, INSTR, WRITE, READ, DRAIN} state_t;
  state_t state, state_nxt;
  logic [CS_SYNC_STAGES-1:0] sclk_s, cs_s, sdi_s, upd_s;
  logic sclk_q, cs_q, upd_q;
  logic rise, fall, cs_fall, cs_rise, upd_rise, sdi, last_bit, commit, bad;
  logic [2:0] bit_cnt, byte_cnt;
  logic [30:0] sh;
  logic [31:0] sh_nxt, tx, rd_word;
  logic [4:0] addr, addr_nxt;
  logic [31:0] b_cfr1, b_ftw;
  logic [23:0] b_cfr2;
  logic [15:0] b_asf, b_pow;
  logic [7:0] b_arr;

  function automatic logic [2:0] len_of(input logic [4:0] a);
    return a == 5'd0 ? 3'd4 : a == 5'd1 ? 3'd3 : a == 5'd2 ? 3'd2 :
           a == 5'd3 ? 3'd1 : a == 5'd4 ? 3'd4 : a == 5'd5 ? 3'd2 : 3'd0;
  endfunction

  // Synchronizers are left unreset so a level already present at reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    sclk_s <= {sclk_s[CS_SYNC_STAGES-2:0], sclk};
    cs_s   <= {cs_s[CS_SYNC_STAGES-2:0], n_cs};
    sdi_s  <= {sdi_s[CS_SYNC_STAGES-2:0], sdio_i};
    upd_s  <= {upd_s[CS_SYNC_STAGES-2:0], io_update};
    sclk_q <= sclk_s[CS_SYNC_STAGES-1];
    cs_q   <= cs_s[CS_SYNC_STAGES-1];
    upd_q  <= upd_s[CS_SYNC_STAGES-1];
  end

  always_comb begin
    rise     = sclk_s[CS_SYNC_STAGES-1] & ~sclk_q;
    fall     = ~sclk_s[CS_SYNC_STAGES-1] & sclk_q;
    cs_fall  = ~cs_s[CS_SYNC_STAGES-1] & cs_q;
    cs_rise  = cs_s[CS_SYNC_STAGES-1] & ~cs_q;
    upd_rise = upd_s[CS_SYNC_STAGES-1] & ~upd_q;
    sdi      = sdi_s[CS_SYNC_STAGES-1];
    last_bit = bit_cnt == 3'd7;
    sh_nxt   = {sh, sdi};
    addr_nxt = sh_nxt[4:0];
    // Read data is left-aligned so the MSB of every register leaves from bit 31.
    rd_word  = addr_nxt == 5'd0 ? b_cfr1 : addr_nxt == 5'd1 ? {b_cfr2, 8'h00} :
               addr_nxt == 5'd2 ? {b_asf, 16'h0000} : addr_nxt == 5'd3 ? {b_arr, 24'h000000} :
               addr_nxt == 5'd4 ? b_ftw : addr_nxt == 5'd5 ? {b_pow, 16'h0000} : 32'h0;
    state_nxt = state;
    commit    = 1'b0;
    bad       = 1'b0;
    if (cs_rise) state_nxt = IDLE;
    else if (state == IDLE) state_nxt = cs_fall ? INSTR : IDLE;
    else if (rise && last_bit) begin
      if (state == INSTR) begin
        bad       = len_of(addr_nxt) == 3'd0;
        state_nxt = bad ? DRAIN : sh[6] ? READ : WRITE;
      end else if ((state == WRITE || state == READ) && byte_cnt == len_of(addr) - 3'd1) begin
        commit    = state == WRITE;
        state_nxt = DRAIN;
      end
    end
  end

  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      {bit_cnt, byte_cnt, addr, sh, tx} <= '0;
      {sdio_o, sdio_oe, wr_done, bad_addr, update_stb, wr_addr} <= '0;
      {b_cfr1, b_cfr2, b_asf, b_arr, b_ftw, b_pow} <= '0;
      {cfr1, cfr2, asf, arr, ftw, pow} <= '0;
    end else begin
      wr_done    <= commit;
      bad_addr   <= bad;
      update_stb <= upd_rise;
      // Buffers and actives share this edge, so a coincident update sees the pre-commit buffer.
      if (upd_rise) {cfr1, cfr2, asf, arr, ftw, pow} <= {b_cfr1, b_cfr2, b_asf, b_arr, b_ftw, b_pow};
      if (commit) begin
        wr_addr <= addr;
        if (addr == 5'd0) b_cfr1 <= sh_nxt;
        if (addr == 5'd1) b_cfr2 <= sh_nxt[23:0];
        if (addr == 5'd2) b_asf <= sh_nxt[15:0];
        if (addr == 5'd3) b_arr <= sh_nxt[7:0];
        if (addr == 5'd4) b_ftw <= sh_nxt;
        if (addr == 5'd5) b_pow <= sh_nxt[15:0];
      end
      if (state_nxt == IDLE) begin
        {bit_cnt, byte_cnt, sdio_o, sdio_oe} <= '0;
        sh <= '0;
      end else if (rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        sh      <= sh_nxt[30:0];
        if (last_bit && state != INSTR) byte_cnt <= byte_cnt + 3'd1;
        if (last_bit && state == INSTR) begin
          addr <= addr_nxt;
          sh   <= '0;
          tx   <= rd_word;
        end
      end else if (fall && state == READ) begin
        sdio_oe <= 1'b1;
        sdio_o  <= tx[31];
        tx      <= {tx[30:0], 1'b0};
      end else if (fall && state == DRAIN) sdio_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spi_slave_9952.sv
// tb_spi_slave_9952: scenario and randomized checks of spi_slave_9952 against a register-map model
module tb_spi_slave_9952;
  logic clk = 1'b0, rst = 1'b1, n_cs = 1'b1, sclk = 1'b0, sdio_i = 1'b0, io_update = 1'b0;
  logic sdio_o, sdio_oe, update_stb, wr_done, bad_addr;
  logic [31:0] cfr1, ftw;
  logic [23:0] cfr2;
  logic [15:0] asf, pow;
  logic [7:0] arr;
  logic [4:0] wr_addr;
  int checks = 0, fails = 0;
  int cyc = 0, wr_cnt = 0, bad_cnt = 0, oe_cnt = 0, wr_cyc = 0, upd_cyc = 0, upd_t0 = 0;
  int exp_wr = 0, exp_bad = 0;
  logic [4:0] exp_wr_addr = 5'd0;
  logic [31:0] buf_m[6], act_m[6];
  int len_m[6] = '{4, 3, 2, 1, 4, 2};
  logic [7:0] txb[8], rxb[8];
  int rise_cyc[64];
  logic oe_at[64];

  spi_slave_9952 dut (
    .clk(clk), .rst(rst), .n_cs(n_cs), .sclk(sclk), .sdio_i(sdio_i), .sdio_o(sdio_o),
    .sdio_oe(sdio_oe), .io_update(io_update), .cfr1(cfr1), .cfr2(cfr2), .asf(asf), .arr(arr),
    .ftw(ftw), .pow(pow), .update_stb(update_stb), .wr_done(wr_done), .wr_addr(wr_addr),
    .bad_addr(bad_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (wr_done) begin wr_cnt++; wr_cyc = cyc; end
    if (bad_addr) bad_cnt++;
    if (update_stb) upd_cyc = cyc;
    if (sdio_oe) oe_cnt++;
  end

  function automatic logic [127:0] exp_act();
    return {act_m[0], act_m[1][23:0], act_m[2][15:0], act_m[3][7:0], act_m[4], act_m[5][15:0]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 6; i++) begin buf_m[i] = 32'h0; act_m[i] = 32'h0; end
    exp_wr_addr = 5'd0;
  endtask

  task automatic model_apply(input int nbits);
    logic [4:0] a;
    int l;
    logic [31:0] v;
    a = txb[0][4:0];
    if (nbits < 8) return;
    if (a > 5'd5) begin exp_bad++; return; end
    l = len_m[a];
    if (txb[0][7] || nbits < 8 * (l + 1)) return;
    v = 32'h0;
    for (int j = 1; j <= l; j++) v = (v << 8) | 32'(txb[j]);
    buf_m[a] = v;
    exp_wr++;
    exp_wr_addr = a;
  endtask

  // SPI master: half-period of 4 clk, data set on the low phase, sampled at the rise.
  task automatic spi_xfer(input int nbits, input int rst_at, input int upd_at);
    n_cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      sdio_i = txb[i / 8][7 - i % 8];
      repeat (4) @(negedge clk);
      if (i == rst_at) begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
      end
      sclk = 1'b1;
      rise_cyc[i] = cyc;
      oe_at[i] = sdio_oe;
      rxb[i / 8][7 - i % 8] = sdio_o;
      if (i == upd_at) io_update = 1'b1;
      repeat (4) @(negedge clk);
      io_update = 1'b0;
    end
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    n_cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_update();
    io_update = 1'b1;
    upd_t0 = cyc;
    repeat (4) @(negedge clk);
    io_update = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if ({cfr1, cfr2, asf, arr, ftw, pow} !== 128'h0) begin
      fails++; $display("FAIL reset_actives got %h expected 0", {cfr1, cfr2, asf, arr, ftw, pow});
    end
    checks++;
    if ({sdio_o, sdio_oe, update_stb, wr_done, bad_addr, wr_addr} !== 10'h0) begin
      fails++; $display("FAIL reset_ctrl got %b expected 0", {sdio_o, sdio_oe, update_stb, wr_done, bad_addr, wr_addr});
    end
    rst = 1'b0;
    model_clear();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_ftw();
    int w0;
    w0 = wr_cnt;
    txb[0] = 8'h04; txb[1] = 8'h12; txb[2] = 8'h34; txb[3] = 8'h56; txb[4] = 8'h78;
    spi_xfer(40, -1, -1);
    model_apply(40);
    checks++;
    if (wr_cnt - w0 !== 1) begin fails++; $display("FAIL ftw_wr_done got %0d pulses expected 1", wr_cnt - w0); end
    checks++;
    if (wr_addr !== 5'h04) begin fails++; $display("FAIL ftw_wr_addr got %h expected 04", wr_addr); end
    checks++;
    if (wr_cyc - rise_cyc[39] !== 3) begin fails++; $display("FAIL wr_done_latency got %0d expected 3", wr_cyc - rise_cyc[39]); end
    checks++;
    if ({cfr1, cfr2, asf, arr, ftw, pow} !== 128'h0) begin
      fails++; $display("FAIL ftw_pre_update got %h expected 0", {cfr1, cfr2, asf, arr, ftw, pow});
    end
    pulse_update();
    act_m = buf_m;
    checks++;
    if (upd_cyc - upd_t0 !== 3) begin fails++; $display("FAIL update_latency got %0d expected 3", upd_cyc - upd_t0); end
    checks++;
    if (ftw !== 32'h12345678) begin fails++; $display("FAIL ftw_value got %h expected 12345678", ftw); end
    checks++;
    if ({cfr1, cfr2, asf, arr, ftw, pow} !== exp_act()) begin
      fails++; $display("FAIL ftw_actives got %h expected %h", {cfr1, cfr2, asf, arr, ftw, pow}, exp_act());
    end
  endtask

  task automatic test_asf_readback();
    logic any_oe, all_oe;
    txb[0] = 8'h02; txb[1] = 8'hBE; txb[2] = 8'hEF;
    spi_xfer(24, -1, -1);
    model_apply(24);
    txb[0] = 8'h82; txb[1] = 8'h00; txb[2] = 8'h00;
    spi_xfer(24, -1, -1);
    checks++;
    if ({rxb[1], rxb[2]} !== 16'hBEEF) begin fails++; $display("FAIL asf_readback got %h expected beef", {rxb[1], rxb[2]}); end
    any_oe = 1'b0;
    all_oe = 1'b1;
    for (int i = 0; i < 8; i++) any_oe |= oe_at[i];
    for (int i = 8; i < 24; i++) all_oe &= oe_at[i];
    checks++;
    if (any_oe !== 1'b0) begin fails++; $display("FAIL oe_during_instr got %b expected 0", any_oe); end
    checks++;
    if (all_oe !== 1'b1) begin fails++; $display("FAIL oe_during_data got %b expected 1", all_oe); end
    checks++;
    if (sdio_oe !== 1'b0) begin fails++; $display("FAIL oe_after_cs got %b expected 0", sdio_oe); end
    checks++;
    if (asf !== 16'h0000) begin fails++; $display("FAIL asf_active got %h expected 0000", asf); end
  endtask

  task automatic test_aborted_write();
    int w0;
    w0 = wr_cnt;
    txb[0] = 8'h00; txb[1] = 8'hAA; txb[2] = 8'hBB;
    spi_xfer(24, -1, -1);
    model_apply(24);
    pulse_update();
    act_m = buf_m;
    checks++;
    if (wr_cnt - w0 !== 0) begin fails++; $display("FAIL abort_wr_done got %0d pulses expected 0", wr_cnt - w0); end
    checks++;
    if (cfr1 !== 32'h0) begin fails++; $display("FAIL abort_cfr1 got %h expected 00000000", cfr1); end
    checks++;
    if ({cfr1, cfr2, asf, arr, ftw, pow} !== exp_act()) begin
      fails++; $display("FAIL abort_actives got %h expected %h", {cfr1, cfr2, asf, arr, ftw, pow}, exp_act());
    end
  endtask

  task automatic test_bad_addr();
    int w0, b0;
    w0 = wr_cnt;
    b0 = bad_cnt;
    txb[0] = 8'h1F; txb[1] = 8'h55;
    spi_xfer(16, -1, -1);
    model_apply(16);
    pulse_update();
    act_m = buf_m;
    checks++;
    if (bad_cnt - b0 !== 1) begin fails++; $display("FAIL bad_addr_pulses got %0d expected 1", bad_cnt - b0); end
    checks++;
    if (wr_cnt - w0 !== 0) begin fails++; $display("FAIL bad_addr_wr_done got %0d expected 0", wr_cnt - w0); end
    checks++;
    if ({cfr1, cfr2, asf, arr, ftw, pow} !== exp_act()) begin
      fails++; $display("FAIL bad_addr_actives got %h expected %h", {cfr1, cfr2, asf, arr, ftw, pow}, exp_act());
    end
  endtask

  task automatic test_simultaneous();
    txb[0] = 8'h03; txb[1] = 8'h01;
    spi_xfer(16, -1, -1);
    model_apply(16);
    pulse_update();
    act_m = buf_m;
    txb[1] = 8'h7F;
    spi_xfer(16, -1, 15);
    act_m = buf_m;
    model_apply(16);
    checks++;
    if (upd_cyc !== wr_cyc) begin fails++; $display("FAIL coincide_cycle update %0d expected commit %0d", upd_cyc, wr_cyc); end
    checks++;
    if (arr !== 8'h01) begin fails++; $display("FAIL coincide_arr got %h expected 01", arr); end
    pulse_update();
    act_m = buf_m;
    checks++;
    if (arr !== 8'h7F) begin fails++; $display("FAIL second_update_arr got %h expected 7f", arr); end
  endtask

  task automatic test_reset_mid_frame();
    int w0, o0;
    txb[0] = 8'h04; txb[1] = 8'h11; txb[2] = 8'h22; txb[3] = 8'h33; txb[4] = 8'h44;
    w0 = wr_cnt;
    o0 = oe_cnt;
    spi_xfer(40, 19, -1);
    model_clear();
    checks++;
    if (wr_cnt - w0 !== 0) begin fails++; $display("FAIL midrst_wr_done got %0d expected 0", wr_cnt - w0); end
    checks++;
    if (oe_cnt - o0 !== 0) begin fails++; $display("FAIL midrst_oe got %0d cycles expected 0", oe_cnt - o0); end
    checks++;
    if ({cfr1, cfr2, asf, arr, ftw, pow, wr_addr} !== {exp_act(), exp_wr_addr}) begin
      fails++; $display("FAIL midrst_cleared got %h expected %h", {cfr1, cfr2, asf, arr, ftw, pow, wr_addr}, {exp_act(), exp_wr_addr});
    end
    txb[1] = 8'hCA; txb[2] = 8'hFE; txb[3] = 8'hF0; txb[4] = 8'h0D;
    spi_xfer(40, -1, -1);
    model_apply(40);
    pulse_update();
    act_m = buf_m;
    checks++;
    if (ftw !== 32'hCAFEF00D) begin fails++; $display("FAIL midrst_ftw got %h expected cafef00d", ftw); end
    checks++;
    if ({cfr1, cfr2, asf, arr, ftw, pow} !== exp_act()) begin
      fails++; $display("FAIL midrst_actives got %h expected %h", {cfr1, cfr2, asf, arr, ftw, pow}, exp_act());
    end
  endtask

  task automatic test_random();
    logic [4:0] a;
    logic rw;
    logic [7:0] eb;
    int l, nb, nbits;
    for (int t = 0; t < 24; t++) begin
      a = 5'($urandom_range(0, 7));
      rw = 1'($urandom_range(0, 1));
      l = a < 5'd6 ? len_m[a] : 0;
      nb = a < 5'd6 ? l + int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
      nbits = 8 + 8 * nb;
      if ($urandom_range(0, 4) == 0) nbits -= int'($urandom_range(1, 8));
      txb[0] = {rw, 2'($urandom), a};
      for (int j = 1; j < 8; j++) txb[j] = 8'($urandom);
      spi_xfer(nbits, -1, -1);
      if (rw && a < 5'd6) begin
        for (int j = 0; 16 + 8 * j <= nbits; j++) begin
          eb = j < l ? 8'(buf_m[a] >> (8 * (l - 1 - j))) : 8'h00;
          checks++;
          if (rxb[j + 1] !== eb) begin
            fails++; $display("FAIL rand_read t%0d addr %0d byte %0d got %h expected %h", t, a, j, rxb[j + 1], eb);
          end
        end
      end
      model_apply(nbits);
      if ($urandom_range(0, 2) == 0) begin pulse_update(); act_m = buf_m; end
      checks++;
      if ({wr_cnt, bad_cnt} !== {exp_wr, exp_bad}) begin
        fails++; $display("FAIL rand_counts t%0d got wr %0d bad %0d expected wr %0d bad %0d", t, wr_cnt, bad_cnt, exp_wr, exp_bad);
      end
      checks++;
      if ({cfr1, cfr2, asf, arr, ftw, pow, wr_addr} !== {exp_act(), exp_wr_addr}) begin
        fails++; $display("FAIL rand_state t%0d got %h expected %h", t, {cfr1, cfr2, asf, arr, ftw, pow, wr_addr}, {exp_act(), exp_wr_addr});
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_ftw();
    test_asf_readback();
    test_aborted_write();
    test_bad_addr();
    test_simultaneous();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/spi_slave_9952.md
# spi_slave_9952

Serial-port responder emulating the AD9952 DDS control interface. It decodes the 3-wire SPI frames produced by our SPI master: instruction byte, then register bytes, with write or read-back. It holds an AD9952-style buffer/active register pair per address and transfers buffer to active on `io_update`. It sits on the far side of the SPI link, either as a DDS model in loop-back benches or as the register front end of an FPGA-resident DDS core.

## Interface
- `CS_SYNC_STAGES`, default 2: synchronizer depth for `sclk`, `n_cs`, `sdio_i` and `io_update`. Legal range is 2..3.
- `clk`  in  1  system clock; all logic runs on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `n_cs`  in  1  SPI chip select, active low, asynchronous to `clk`.
- `sclk`  in  1  SPI clock, idle low, asynchronous to `clk`.
- `sdio_i`  in  1  SDIO pad input.
- `sdio_o`  out  1  SDIO pad output data.
- `sdio_oe`  out  1  SDIO pad output enable; 1 means the slave drives the pad.
- `io_update`  in  1  buffer→active transfer request, rising-edge sensitive, asynchronous.
- `cfr1`  out  32  active CFR1 (address 0x00).
- `cfr2`  out  24  active CFR2 (address 0x01).
- `asf`  out  16  active ASF (address 0x02).
- `arr`  out  8  active ARR (address 0x03).
- `ftw`  out  32  active FTW0 (address 0x04).
- `pow`  out  16  active POW0 (address 0x05).
- `update_stb`  out  1  one-cycle pulse; asserted in the cycle the active registers take new values.
- `wr_done`  out  1  one-cycle pulse when a complete write commits to a buffer register.
- `wr_addr`  out  5  address of the last committed write; valid with `wr_done` and held afterwards.
- `bad_addr`  out  1  one-cycle pulse when an instruction byte names an address outside 0x00..0x05.

## Operation
- Clocking: all inputs pass through `CS_SYNC_STAGES` flops. Edges are detected on the synchronized copies. The legal `sclk` high and low times are each ≥4 `clk` cycles.
- Bit order: MSB first. Sampling happens on a synchronized `sclk` rise. Slave output changes on a synchronized `sclk` fall.
- Instruction byte:
  - bit7 = R/W: 1 means read.
  - bits6:5 are ignored.
  - bits4:0 are the address.
  - Register byte length per address: 0x00 = 4, 0x01 = 3, 0x02 = 2, 0x03 = 1, 0x04 = 4, 0x05 = 2. Unknown addresses have length 0.
- FSM states are IDLE, INSTR, WRITE, READ, DRAIN.
  - IDLE → INSTR on a synchronized `n_cs` fall. The bit counter and shift register clear.
  - INSTR → WRITE or READ after the 8th bit, for a valid address.
  - INSTR → DRAIN after the 8th bit for an unknown address. `bad_addr` pulses once.
  - WRITE: bits shift into a staging register of the register's width. When byte count = length, the staging value commits to the buffer register and `wr_done` pulses; then the FSM goes to DRAIN.
  - READ: `sdio_oe` = 1 from the first synchronized `sclk` fall after the 8th instruction bit. The buffer register is shifted out MSB first. After the last bit the FSM goes to DRAIN.
  - DRAIN: bits are ignored. In a read transaction `sdio_o` = 0 and `sdio_oe` stays 1 until `n_cs` rises.
  - Any state → IDLE on a synchronized `n_cs` rise. `sdio_oe` drops in the same cycle.
- Partial write (`n_cs` rises before the last byte completes): the staging data is discarded, the buffer is unchanged and `wr_done` does not pulse.
- Extra bytes beyond the register length are ignored on write and read as 0x00.
- Reads return the buffer register, not the active register.
- `io_update`: on a synchronized rising edge, all six active registers load from their buffers in one cycle, with `update_stb` = 1. This is legal while a transfer is in progress. If it coincides with a commit, the active register takes the pre-commit buffer value.
- Reset values:
  - All buffer and active registers are 0.
  - `sdio_o`, `sdio_oe`, `update_stb`, `wr_done` and `bad_addr` are 0.
  - `wr_addr` is 0x00.
  - FSM is in IDLE.
  - A reset during a frame aborts it. The FSM waits in IDLE for the next `n_cs` fall; an `n_cs` already low at reset release is not treated as a frame start.

## Timing
- Latency from a physical `sclk` rise to the sample is `CS_SYNC_STAGES` + 1 `clk` cycles.
- Latency from a physical `sclk` fall to a valid `sdio_o`/`sdio_oe` is `CS_SYNC_STAGES` + 1 ≤ 4 `clk` cycles. This is valid before the next master sample at the minimum half-period.
- `wr_done` asserts `CS_SYNC_STAGES` + 1 cycles after the physical `sclk` rise of the last data bit.
- `update_stb` asserts `CS_SYNC_STAGES` + 1 cycles after a physical `io_update` rise. Active outputs change in the same cycle.
- Back-to-back frames need `n_cs` high for ≥4 `clk` cycles.

## Test plan
- Write FTW: write 0x04 with bytes 0x12 0x34 0x56 0x78 (`sclk` = `clk`/8), then pulse `io_update`.
  - `wr_done` = 1 and `wr_addr` = 0x04.
  - `ftw` stays 0 until `update_stb`, then `ftw` = 0x12345678.
  - All other outputs stay 0.
- ASF read-back: write 0x02 with 0xBEEF with no `io_update`, then read 0x82.
  - Master captures 0xBE 0xEF.
  - `sdio_oe` = 1 only during the data bytes.
  - `asf` stays 0x0000.
- Aborted write: write 0x00 with 0xAA 0xBB, then raise `n_cs`; then pulse `io_update`.
  - No `wr_done`.
  - `cfr1` = 0x00000000.
- Unknown address: instruction 0x1F followed by byte 0x55.
  - `bad_addr` pulses once.
  - No `wr_done`.
  - Registers unchanged.
- Simultaneous events: assert `io_update` in the same synchronized cycle as the ARR commit of 0x7F, with the old ARR buffer = 0x01.
  - `arr` = 0x01.
  - A second `io_update` gives `arr` = 0x7F.
- Reset mid-frame: assert `rst` during the 2nd FTW byte, release it with `n_cs` still low, then run a clean write of FTW 0xCAFEF00D and `io_update`.
  - Remainder of the interrupted frame: no `wr_done`, `sdio_oe` = 0.
  - After the clean write: `ftw` = 0xCAFEF00D.
